// File: rtl/hidden_result_collector_pkg.sv
// Shared ELM definitions: collector FSM encodings, activation width and
// the default hidden-layer size.
package hidden_result_collector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_e;

   localparam int ACT_W           = 8;
   localparam int NUM_NEURONS_DEF = 16;

   localparam logic [ACT_W-1:0] ACT_MAX = '1;

endpackage

// File: rtl/hidden_result_collector_sync_fifo.sv
// Single-clock FIFO with a combinational head (zero read latency).
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/hidden_result_collector.sv
// Collects hidden-layer neuron sums, applies shift + saturating activation,
// and streams {value, index} beats downstream through a small FIFO.
module hidden_result_collector
   import hidden_result_collector_pkg::*;
#(
   parameter  int NUM_NEURONS = NUM_NEURONS_DEF,
   parameter  int ACC_W       = 20,
   parameter  int SHIFT       = 4,
   parameter  int FIFO_DEPTH  = 8,
   localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    per_load,
   input  logic signed [ACC_W-1:0] acc_value,
   output logic                    stop,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACT_W-1:0]        out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    overflow,
   output logic                    busy
);

   localparam int CNT_W      = $clog2(NUM_NEURONS + 1);
   localparam int ENTRY_W    = ACT_W + IDX_W;
   localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [ACT_W-1:0]   last_data_q, last_data_d;
   logic [IDX_W-1:0]   last_idx_q, last_idx_d;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_flush;
   logic               fifo_full;
   logic               fifo_empty;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   logic [ACT_W-1:0]   head_data;
   logic [IDX_W-1:0]   head_idx;

   // Arithmetic shift, then clamp to the unsigned 8-bit activation range.
   function automatic logic [ACT_W-1:0] activate(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] a;
      a = v >>> SHIFT;
      if (a[ACC_W-1])            return '0;
      if (|a[ACC_W-1:ACT_W])     return ACT_MAX;
      return a[ACT_W-1:0];
   endfunction

   assign fifo_din  = {activate(acc_value), count_q[IDX_W-1:0]};
   assign head_data = fifo_dout[IDX_W +: ACT_W];
   assign head_idx  = fifo_dout[IDX_W-1:0];

   assign out_valid = !fifo_empty;
   assign fifo_pop  = out_valid && out_ready;

   // With the FIFO empty the outputs fall back to the last transferred beat.
   assign out_data  = fifo_empty ? last_data_q : head_data;
   assign out_idx   = fifo_empty ? last_idx_q  : head_idx;
   assign out_last  = (out_idx == IDX_W'(NUM_NEURONS - 1));

   assign stop      = (count_q == CNT_W'(NUM_NEURONS));
   assign overflow  = overflow_q;
   assign busy      = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      fifo_push   = 1'b0;
      fifo_flush  = 1'b0;
      last_data_d = last_data_q;
      last_idx_d  = last_idx_q;

      if (fifo_pop) begin
         last_data_d = head_data;
         last_idx_d  = head_idx;
      end

      // start takes priority over a coincident per_load and aborts any pass.
      if (start) begin
         state_d    = COLLECT;
         count_d    = '0;
         overflow_d = 1'b0;
         fifo_flush = 1'b1;
      end else begin
         case (state_q)
            COLLECT: begin
               if (per_load) begin
                  fifo_push = 1'b1;
                  count_d   = count_q + CNT_W'(1);
                  if (fifo_full && !fifo_pop) overflow_d = 1'b1;
                  if (count_q == CNT_W'(NUM_NEURONS - 1)) state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_pop && fifo_count == FIFO_CNT_W'(1)) state_d = DONE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         last_data_q <= '0;
         last_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         last_data_q <= last_data_d;
         last_idx_q  <= last_idx_d;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_hidden_result_collector.sv
// Directed bench for hidden_result_collector: collects transferred beats with a
// negedge monitor and compares them against hand-computed expectations.
module tb_hidden_result_collector;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               per_load;
   logic signed [19:0] acc_value;
   logic               stop;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_data;
   logic [3:0]         out_idx;
   logic               out_last;
   logic               overflow;
   logic               busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] q_data [$];
   logic [3:0] q_idx  [$];
   logic       q_last [$];

   always #5 clk = ~clk;

   hidden_result_collector dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .per_load  (per_load),
      .acc_value (acc_value),
      .stop      (stop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .overflow  (overflow),
      .busy      (busy)
   );

   // Record every beat that will transfer on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         q_data.push_back(out_data);
         q_idx.push_back(out_idx);
         q_last.push_back(out_last);
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_beats();
      q_data.delete();
      q_idx.delete();
      q_last.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load(input int value);
      per_load  = 1'b1;
      acc_value = 20'(value);
      step();
      per_load  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; per_load = 1'b0; acc_value = '0; out_ready = 1'b0;
      step(2);
      rst = 1'b0;

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data, 0);
      check("rst_out_idx",   out_idx, 0);
      check("rst_out_last",  out_last, 0);
      check("rst_overflow",  overflow, 0);
      check("rst_busy",      busy, 0);
      check("rst_stop",      stop, 0);

      // Full pass with k*32 -> 2k
      clear_beats();
      out_ready = 1'b1;
      pulse_start();
      check("pass_busy", busy, 1);
      for (int k = 0; k < 16; k++) begin
         check("pass_stop_pre", stop, 0);
         load(k * 32);
      end
      check("pass_stop", stop, 1);
      step(3);
      check("pass_beats", q_data.size(), 16);
      for (int k = 0; k < 16 && k < q_data.size(); k++) begin
         check($sformatf("pass_data%0d", k), q_data[k], 2 * k);
         check($sformatf("pass_idx%0d", k),  q_idx[k], k);
         check($sformatf("pass_last%0d", k), q_last[k], (k == 15) ? 1 : 0);
      end
      check("done_busy",       busy, 1);
      check("done_stop_hold",  stop, 1);
      check("empty_valid",     out_valid, 0);
      check("empty_hold_data", out_data, 30);
      check("empty_hold_idx",  out_idx, 15);
      check("empty_hold_last", out_last, 1);

      // Activation boundaries
      clear_beats();
      pulse_start();
      check("act_stop_clr", stop, 0);
      load(-100);
      load(20'h3FFFF);
      load(20'h00FF0);
      load(20'h0007F);
      step(2);
      check("act_beats", q_data.size(), 4);
      if (q_data.size() == 4) begin
         check("act_neg",   q_data[0], 0);
         check("act_big",   q_data[1], 255);
         check("act_edge",  q_data[2], 255);
         check("act_small", q_data[3], 7);
      end

      // Overflow: 9 loads with out_ready low
      clear_beats();
      out_ready = 1'b0;
      pulse_start();
      for (int k = 0; k < 9; k++) load(k * 32);
      check("ovf_flag",  overflow, 1);
      check("ovf_stop",  stop, 0);
      check("ovf_valid", out_valid, 1);
      check("ovf_head",  out_idx, 0);
      out_ready = 1'b1;
      step(8);
      check("ovf_drain_beats", q_data.size(), 8);
      check("ovf_drain_empty", out_valid, 0);
      for (int k = 9; k < 16; k++) load(k * 32);
      check("ovf_stop_after9", stop, 1);
      step(2);
      check("ovf_total_beats", q_idx.size(), 15);
      if (q_idx.size() == 15) begin
         check("ovf_idx7",  q_idx[7], 7);
         check("ovf_idx8",  q_idx[8], 9);
         check("ovf_data8", q_data[8], 18);
         check("ovf_last",  q_last[14], 1);
      end

      // Full buffer with simultaneous push and pop
      out_ready = 1'b0;
      pulse_start();
      check("fp_ovf_clr", overflow, 0);
      for (int k = 0; k < 8; k++) load(k * 32);
      check("fp_ovf_pre", overflow, 0);
      clear_beats();
      out_ready = 1'b1;
      load(8 * 32);
      out_ready = 1'b0;
      check("fp_ovf_post", overflow, 0);
      check("fp_popped",   q_idx.size(), 1);
      out_ready = 1'b1;
      step(8);
      check("fp_empty",    out_valid, 0);
      check("fp_beats",    q_idx.size(), 9);
      if (q_idx.size() == 9) begin
         check("fp_idx8",  q_idx[8], 8);
         check("fp_data8", q_data[8], 16);
      end

      // start aborts a pass
      out_ready = 1'b0;
      pulse_start();
      for (int k = 0; k < 5; k++) load(k * 32);
      check("abort_pre_valid", out_valid, 1);
      pulse_start();
      check("abort_empty", out_valid, 0);
      check("abort_stop",  stop, 0);
      check("abort_busy",  busy, 1);
      clear_beats();
      out_ready = 1'b1;
      load(3 * 32);
      step();
      check("abort_beats", q_idx.size(), 1);
      if (q_idx.size() == 1) begin
         check("abort_idx",  q_idx[0], 0);
         check("abort_data", q_data[0], 6);
      end

      // start and per_load together: sample discarded
      clear_beats();
      start = 1'b1; per_load = 1'b1; acc_value = 20'd320;
      step();
      start = 1'b0; per_load = 1'b0;
      step(2);
      check("sp_no_beat", q_idx.size(), 0);
      load(64);
      step();
      check("sp_next_beat", q_idx.size(), 1);
      if (q_idx.size() == 1) check("sp_next_idx", q_idx[0], 0);

      // Reset during DRAIN with 3 entries queued
      pulse_start();
      out_ready = 1'b1;
      for (int k = 0; k < 13; k++) load(k * 32);
      step();
      out_ready = 1'b0;
      for (int k = 13; k < 16; k++) load(k * 32);
      check("drain_stop",  stop, 1);
      check("drain_busy",  busy, 1);
      check("drain_valid", out_valid, 1);
      check("drain_head",  out_idx, 13);
      clear_beats();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst2_valid",    out_valid, 0);
      check("rst2_busy",     busy, 0);
      check("rst2_stop",     stop, 0);
      check("rst2_data",     out_data, 0);
      check("rst2_overflow", overflow, 0);
      out_ready = 1'b1;
      load(32);
      step();
      check("rst2_ignore_valid", out_valid, 0);
      check("rst2_ignore_busy",  busy, 0);
      check("rst2_no_beats",     q_idx.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
